control_sequencer: RTL and testbench

- Hardwired control unit that generates, every cycle, the datapath control strobes the benches currently drive by hand.
- Runs the three-cycle instruction fetch, decodes the IR opcode, and steps through the execute sequence for each supported instruction.
- Sits beside the datapath. Consumes the opcode field and the CON flip-flop output; drives every datapath control input using the datapath's own port names.

---
 rtl/control_sequencer_if.sv | 26 ++
 rtl/control_sequencer.sv | 106 ++++++++++
 tb/tb_control_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: opcode/condition inputs and all datapath control strobes
interface control_sequencer_if #(parameter int OPW = 5);
    logic [OPW-1:0] ir_op;
    logic           CON;
    logic           run;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, RCout;
    logic RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin, CONin;
    logic InPortIn, InPortout, OutPortIn;
    modport master (
        input  ir_op, CON,
        output run,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin,
        output Gra, Grb, Grc, Rin, Rout, BAout, RCout,
        output RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin, CONin,
        output InPortIn, InPortout, OutPortIn
    );
    modport slave (
        output ir_op, CON,
        input  run,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin,
        input  Gra, Grb, Grc, Rin, Rout, BAout, RCout,
        input  RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin, CONin,
        input  InPortIn, InPortout, OutPortIn
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute step generator for the datapath
module control_sequencer #(parameter int OPW = 5) (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);
    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b01001;
    localparam logic [OPW-1:0] OP_OR   = 5'b01010;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_IN   = 5'b10101;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    logic [3:0] state_q, state_d, last_st;
    logic t0, t1, t2, t3, t4, t5, t6, t7;
    logic is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_in, is_out, is_halt;
    logic is_ari, is_ya;

    assign is_alu  = bus.ir_op == OP_ADD || bus.ir_op == OP_SUB || bus.ir_op == OP_AND || bus.ir_op == OP_OR;
    assign is_imm  = bus.ir_op == OP_ADDI || bus.ir_op == OP_ANDI || bus.ir_op == OP_ORI;
    assign is_ldi  = bus.ir_op == OP_LDI;
    assign is_ld   = bus.ir_op == OP_LD;
    assign is_st   = bus.ir_op == OP_ST;
    assign is_br   = bus.ir_op == OP_BR;
    assign is_jr   = bus.ir_op == OP_JR;
    assign is_in   = bus.ir_op == OP_IN;
    assign is_out  = bus.ir_op == OP_OUT;
    assign is_halt = bus.ir_op == OP_HALT;
    // is_ari: write-back in T5; is_ya: shares the Y/Z address-style T3..T5 prologue
    assign is_ari  = is_alu | is_imm | is_ldi;
    assign is_ya   = is_ari | is_ld | is_st;

    assign t0 = state_q == S_T0;
    assign t1 = state_q == S_T1;
    assign t2 = state_q == S_T2;
    assign t3 = state_q == S_T3;
    assign t4 = state_q == S_T4;
    assign t5 = state_q == S_T5;
    assign t6 = state_q == S_T6;
    assign t7 = state_q == S_T7;

    // Next step: fetch runs T0..T2, execute runs to the opcode's last step then returns to T0
    always_comb begin
        last_st = is_ari ? S_T5 : (is_ld | is_st | is_br) ? S_T7 : S_T3;
        state_d = state_q == S_RST                ? S_T0 :
                  state_q == S_HALT               ? S_HALT :
                  (t3 && is_halt)                 ? S_HALT :
                  (state_q == last_st || t7)      ? S_T0 :
                                                    state_q + 4'd1;
    end

    // Single step register; clear parks it in RST where every strobe is low
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= S_RST;
        else       state_q <= state_d;
    end

    assign bus.run       = state_q != S_HALT;
    assign bus.PCout     = t0 | (t4 & is_br);
    assign bus.PCin      = (t3 & is_jr) | (t6 & is_br & bus.CON);
    assign bus.IncPC     = t0;
    assign bus.MARin     = t0 | (t5 & (is_ld | is_st));
    assign bus.MDRin     = t1 | (t6 & (is_ld | is_st));
    assign bus.MDRout    = t2 | (t7 & is_ld);
    assign bus.MDRread   = t1 | (t6 & is_ld);
    assign bus.RAMwrite  = t7 & is_st;
    assign bus.IRin      = t2;
    assign bus.Gra       = (t5 & is_ari) | (t7 & is_ld) | (t6 & is_st) | (t3 & (is_br | is_jr | is_in | is_out));
    assign bus.Grb       = t3 & is_ya;
    assign bus.Grc       = t4 & is_alu;
    assign bus.Rin       = (t5 & is_ari) | (t7 & is_ld) | (t3 & is_in);
    assign bus.Rout      = (t3 & (is_alu | is_imm | is_br | is_jr | is_out)) | (t4 & is_alu) | (t6 & is_st);
    assign bus.BAout     = t3 & (is_ldi | is_ld | is_st);
    assign bus.RCout     = (t4 & (is_imm | is_ldi | is_ld | is_st)) | (t5 & is_br);
    assign bus.RYin      = (t3 & is_ya) | (t4 & is_br);
    assign bus.RZinLo    = (t4 & is_ya) | (t5 & is_br);
    assign bus.RZinHi    = 1'b0;
    assign bus.RZoutLo   = (t5 & is_ya) | (t6 & is_br & bus.CON);
    assign bus.RZoutHi   = 1'b0;
    assign bus.LOin      = 1'b0;
    assign bus.HIin      = 1'b0;
    assign bus.CONin     = t3 & is_br;
    assign bus.InPortIn  = 1'b0;
    assign bus.InPortout = t3 & is_in;
    assign bus.OutPortIn = t3 & is_out;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-instruction strobe schedules compared cycle by cycle
module tb_control_sequencer;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    control_sequencer_if #(.OPW(5)) bus();
    control_sequencer #(.OPW(5)) dut (.clock(clock), .clear(clear), .bus(bus));

    always #5 clock = ~clock;

    localparam logic [26:0] M_PCOUT     = 27'd1 << 0;
    localparam logic [26:0] M_PCIN      = 27'd1 << 1;
    localparam logic [26:0] M_INCPC     = 27'd1 << 2;
    localparam logic [26:0] M_MARIN     = 27'd1 << 3;
    localparam logic [26:0] M_MDRIN     = 27'd1 << 4;
    localparam logic [26:0] M_MDROUT    = 27'd1 << 5;
    localparam logic [26:0] M_MDRREAD   = 27'd1 << 6;
    localparam logic [26:0] M_RAMWRITE  = 27'd1 << 7;
    localparam logic [26:0] M_IRIN      = 27'd1 << 8;
    localparam logic [26:0] M_GRA       = 27'd1 << 9;
    localparam logic [26:0] M_GRB       = 27'd1 << 10;
    localparam logic [26:0] M_GRC       = 27'd1 << 11;
    localparam logic [26:0] M_RIN       = 27'd1 << 12;
    localparam logic [26:0] M_ROUT      = 27'd1 << 13;
    localparam logic [26:0] M_BAOUT     = 27'd1 << 14;
    localparam logic [26:0] M_RCOUT     = 27'd1 << 15;
    localparam logic [26:0] M_RYIN      = 27'd1 << 16;
    localparam logic [26:0] M_RZINLO    = 27'd1 << 17;
    localparam logic [26:0] M_RZOUTLO   = 27'd1 << 19;
    localparam logic [26:0] M_RZOUTHI   = 27'd1 << 20;
    localparam logic [26:0] M_CONIN     = 27'd1 << 23;
    localparam logic [26:0] M_INPORTOUT = 27'd1 << 25;
    localparam logic [26:0] M_OUTPORTIN = 27'd1 << 26;
    localparam logic [26:0] BUS_M = M_PCOUT | M_MDROUT | M_ROUT | M_BAOUT | M_RCOUT |
                                    M_RZOUTLO | M_RZOUTHI | M_INPORTOUT;

    logic [26:0] exp_q[$];

    function automatic logic [26:0] strobes();
        return {bus.OutPortIn, bus.InPortout, bus.InPortIn, bus.CONin, bus.HIin, bus.LOin,
                bus.RZoutHi, bus.RZoutLo, bus.RZinHi, bus.RZinLo, bus.RYin, bus.RCout,
                bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.IRin,
                bus.RAMwrite, bus.MDRread, bus.MDRout, bus.MDRin, bus.MARin, bus.IncPC,
                bus.PCin, bus.PCout};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference schedule: fetch, then the instruction's execute steps, one entry per cycle
    task automatic build(input logic [4:0] op, input logic con);
        exp_q = {M_PCOUT | M_MARIN | M_INCPC, M_MDRREAD | M_MDRIN, M_MDROUT | M_IRIN};
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010:
                exp_q = {exp_q, M_GRB | M_ROUT | M_RYIN, M_GRC | M_ROUT | M_RZINLO, M_RZOUTLO | M_GRA | M_RIN};
            5'b01011, 5'b01100, 5'b01101:
                exp_q = {exp_q, M_GRB | M_ROUT | M_RYIN, M_RCOUT | M_RZINLO, M_RZOUTLO | M_GRA | M_RIN};
            5'b00001:
                exp_q = {exp_q, M_GRB | M_BAOUT | M_RYIN, M_RCOUT | M_RZINLO, M_RZOUTLO | M_GRA | M_RIN};
            5'b00000:
                exp_q = {exp_q, M_GRB | M_BAOUT | M_RYIN, M_RCOUT | M_RZINLO, M_RZOUTLO | M_MARIN,
                         M_MDRREAD | M_MDRIN, M_MDROUT | M_GRA | M_RIN};
            5'b00010:
                exp_q = {exp_q, M_GRB | M_BAOUT | M_RYIN, M_RCOUT | M_RZINLO, M_RZOUTLO | M_MARIN,
                         M_GRA | M_ROUT | M_MDRIN, M_RAMWRITE};
            5'b10010:
                exp_q = {exp_q, M_GRA | M_ROUT | M_CONIN, M_PCOUT | M_RYIN, M_RCOUT | M_RZINLO,
                         con ? (M_RZOUTLO | M_PCIN) : 27'd0, 27'd0};
            5'b10011: exp_q = {exp_q, M_GRA | M_ROUT | M_PCIN};
            5'b10101: exp_q = {exp_q, M_INPORTOUT | M_GRA | M_RIN};
            5'b10110: exp_q = {exp_q, M_GRA | M_ROUT | M_OUTPORTIN};
            default:  exp_q = {exp_q, 27'd0};
        endcase
    endtask

    // Entered at a negedge inside T0; leaves at the negedge after the last step
    task automatic run_instr(input logic [4:0] op, input logic con);
        build(op, con);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clock);
            check($sformatf("op%b_step%0d", op, i), {5'd0, strobes()}, {5'd0, exp_q[i]});
            check($sformatf("op%b_run%0d", op, i), {31'd0, bus.run}, 32'd1);
            check($sformatf("op%b_excl%0d", op, i), {31'd0, $countones(strobes() & BUS_M) <= 1}, 32'd1);
            if (i == 0) begin
                bus.ir_op = 5'($urandom);
                bus.CON = 1'($urandom);
            end
            if (i == 2) begin
                bus.ir_op = op;
                bus.CON = con;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        logic [4:0] rop;
        bus.ir_op = 5'd0;
        bus.CON = 1'b0;
        #1 clear = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_strobes", {5'd0, strobes()}, 32'd0);
        check("rst_run", {31'd0, bus.run}, 32'd1);
        clear = 1'b0;
        @(negedge clock);
        run_instr(5'b00011, 1'b0);
        run_instr(5'b00000, 1'b0);
        run_instr(5'b00010, 1'b0);
        run_instr(5'b10010, 1'b1);
        run_instr(5'b10010, 1'b0);
        run_instr(5'b10011, 1'b0);
        run_instr(5'b10101, 1'b0);
        run_instr(5'b10110, 1'b0);
        run_instr(5'b11001, 1'b0);
        run_instr(5'b11111, 1'b1);
        run_instr(5'b00001, 1'b0);
        run_instr(5'b01100, 1'b0);
        for (int k = 0; k < 60; k++) begin
            rop = 5'($urandom_range(0, 31));
            if (rop == 5'b11010) rop = 5'b11001;
            run_instr(rop, 1'($urandom));
        end
        run_instr(5'b11010, 1'b0);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("halt_strobes%0d", k), {5'd0, strobes()}, 32'd0);
            check($sformatf("halt_run%0d", k), {31'd0, bus.run}, 32'd0);
            bus.ir_op = 5'($urandom);
            @(negedge clock);
        end
        clear = 1'b1;
        #1 check("halt_clear_run", {31'd0, bus.run}, 32'd1);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        run_instr(5'b00011, 1'b0);
        build(5'b00000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clock);
            check($sformatf("ldclr_step%0d", i), {5'd0, strobes()}, {5'd0, exp_q[i]});
            if (i == 2) bus.ir_op = 5'b00000;
        end
        #2 clear = 1'b1;
        #1 check("midclr_strobes", {5'd0, strobes()}, 32'd0);
        check("midclr_run", {31'd0, bus.run}, 32'd1);
        @(negedge clock);
        check("midclr_hold", {5'd0, strobes()}, 32'd0);
        check("midclr_ramwrite_rin", {30'd0, bus.RAMwrite, bus.Rin}, 32'd0);
        clear = 1'b0;
        @(negedge clock);
        run_instr(5'b01010, 1'b0);
        run_instr(5'b00010, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
